crc_serial_tx: RTL and testbench

- Parametrised bit-serial CRC frame transmitter. Next generation of the team's fixed 11-bit/CRC5 sender.
- Accepts a parallel message word over a valid/ready handshake, serialises it MSB first, then appends the CRC remainder (optionally complemented).
- Supports transmit stall (tx_en), abort, and back-to-back frames with no idle gap.
- Sits between the packet source and the serial line driver; its output feeds the matching CRC checker.

---
 rtl/crc_pkg.sv | 24 ++
 rtl/crc_lfsr.sv | 45 ++++
 rtl/crc_serial_tx.sv | 155 +++++++++++++++
 tb/tb_crc_serial_tx.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and constants for the serial CRC transmitter and checker
package crc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MSG  = 2'd1,
    CRC  = 2'd2
  } tx_state_e;

  // CRC5 defaults (x^5 + x^2 + 1, all-ones preset)
  localparam logic [4:0]  CRC5_POLY    = 5'h05;
  localparam logic [4:0]  CRC5_INIT    = 5'h1F;
  // Checker remainder after a good frame sent with a complemented CRC
  localparam logic [4:0]  CRC5_RESIDUE = 5'h0C;

  // CRC16 (x^16 + x^15 + x^2 + 1, all-ones preset)
  localparam logic [15:0] CRC16_POLY   = 16'h8005;
  localparam logic [15:0] CRC16_INIT   = 16'hFFFF;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/crc_lfsr.sv
// rtl/crc_lfsr.sv - Galois CRC LFSR with preset, data step and zero-fill unload
// Ports:
//   ck        clock
//   rst       asynchronous active-low reset (loads INIT)
//   init      load INIT (highest priority)
//   step      advance one data bit: fb = in ^ msb; crc = (crc << 1) ^ (fb ? POLY : 0)
//   shift_out shift left with zero fill (unloads the remainder MSB first)
//   in        serial data bit for step
//   crc       current register contents
module crc_lfsr
  import crc_pkg::*;
#(
  parameter int          CRC_W = 5,
  parameter logic [31:0] POLY  = 32'(CRC5_POLY),
  parameter logic [31:0] INIT  = 32'(CRC5_INIT)
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             init,
  input  logic             step,
  input  logic             shift_out,
  input  logic             in,
  output logic [CRC_W-1:0] crc
);

  // POLY/INIT are carried as 32-bit values and cut down to the register width
  localparam logic [CRC_W-1:0] POLY_W = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_W = INIT[CRC_W-1:0];

  logic fb;
  assign fb = in ^ crc[CRC_W-1];

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      crc <= INIT_W;
    end else if (init) begin
      crc <= INIT_W;
    end else if (step) begin
      crc <= (crc << 1) ^ (fb ? POLY_W : '0);
    end else if (shift_out) begin
      crc <= crc << 1;
    end
  end

endmodule

// File: rtl/crc_serial_tx.sv
// rtl/crc_serial_tx.sv - bit-serial CRC frame transmitter (message MSB first, then CRC)
// Ports:
//   ck         clock
//   rst        asynchronous active-low reset
//   msg_valid  msg_data valid
//   msg_ready  message accepted this cycle when msg_valid (combinational)
//   msg_data   message word, bit MSG_LEN-1 sent first
//   tx_en      line advance enable, 0 stalls all state
//   abort      drop the current frame, back to IDLE next cycle
//   tx_bit     serial data
//   tx_valid   tx_bit belongs to a frame
//   tx_last    tx_bit is the final CRC bit
//   busy       frame in progress
module crc_serial_tx
  import crc_pkg::*;
#(
  parameter int          MSG_LEN    = 11,
  parameter int          CRC_W      = 5,
  parameter logic [31:0] POLY       = 32'(CRC5_POLY),
  parameter logic [31:0] INIT       = 32'(CRC5_INIT),
  parameter bit          INVERT_OUT = 1'b1
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               msg_valid,
  output logic               msg_ready,
  input  logic [MSG_LEN-1:0] msg_data,
  input  logic               tx_en,
  input  logic               abort,
  output logic               tx_bit,
  output logic               tx_valid,
  output logic               tx_last,
  output logic               busy
);

  localparam int CNT_W = $clog2(max_int(MSG_LEN, CRC_W) + 1);
  localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_LEN - 1);
  localparam logic [CNT_W-1:0] CRC_LAST = CNT_W'(CRC_W - 1);

  tx_state_e          state;
  logic [MSG_LEN-1:0] shift_reg;
  logic [CNT_W-1:0]   count;
  logic [CRC_W-1:0]   crc_q;
  logic               accept;
  logic               advance;
  logic               in_crc_last;
  logic               msg_bit;
  logic               crc_bit;
  logic               crc_unused;

  assign msg_bit     = shift_reg[MSG_LEN-1];
  assign crc_bit     = crc_q[CRC_W-1] ^ INVERT_OUT;
  // Only the MSB leaves the LFSR; the rest is internal remainder state
  assign crc_unused  = ^crc_q[CRC_W-2:0];

  // A line step happens only when enabled and not being aborted
  assign advance     = tx_en && !abort;
  assign in_crc_last = (state == CRC) && (count == CRC_LAST);

  // Ready in IDLE, or on the final CRC bit so the next frame follows with no gap
  assign msg_ready   = (state == IDLE) || (in_crc_last && advance);
  assign accept      = msg_valid && msg_ready;

  crc_lfsr #(
    .CRC_W (CRC_W),
    .POLY  (POLY),
    .INIT  (INIT)
  ) u_lfsr (
    .ck        (ck),
    .rst       (rst),
    .init      (accept),
    .step      ((state == MSG) && advance),
    .shift_out ((state == CRC) && advance),
    .in        (msg_bit),
    .crc       (crc_q)
  );

  always_ff @(posedge ck or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      count     <= '0;
    end else if (abort && (state != IDLE)) begin
      state <= IDLE;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            shift_reg <= msg_data;
            count     <= '0;
            state     <= MSG;
          end
        end
        MSG: begin
          if (tx_en) begin
            shift_reg <= shift_reg << 1;
            if (count == MSG_LAST) begin
              count <= '0;
              state <= CRC;
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        CRC: begin
          if (tx_en) begin
            if (count == CRC_LAST) begin
              count <= '0;
              if (accept) begin
                shift_reg <= msg_data;
                state     <= MSG;
              end else begin
                state <= IDLE;
              end
            end else begin
              count <= count + CNT_W'(1);
            end
          end
        end
        default: begin
          state <= IDLE;
          count <= '0;
        end
      endcase
    end
  end

  // Outputs decode directly from registered state, so a stall holds them
  // and reset clears them without waiting for a clock.
  always_comb begin
    tx_bit   = 1'b0;
    tx_valid = 1'b0;
    tx_last  = 1'b0;
    busy     = 1'b0;
    case (state)
      MSG: begin
        tx_bit   = msg_bit;
        tx_valid = 1'b1;
        busy     = 1'b1;
      end
      CRC: begin
        tx_bit   = crc_bit;
        tx_valid = 1'b1;
        tx_last  = in_crc_last;
        busy     = 1'b1;
      end
      default: begin
        tx_bit   = 1'b0;
        tx_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_crc_serial_tx.sv
// tb/tb_crc_serial_tx.sv - self-checking bench for crc_serial_tx (CRC5 default and CRC16/32-bit)
module tb_crc_serial_tx;
  import crc_pkg::*;

  logic ck = 1'b0;
  always #5 ck = ~ck;
  logic rst;

  // Default instance: MSG_LEN=11, CRC5, inverted output
  logic        a_msg_valid, a_msg_ready, a_tx_en, a_abort;
  logic [10:0] a_msg_data;
  logic        a_tx_bit, a_tx_valid, a_tx_last, a_busy;

  // Wide instance: MSG_LEN=32, CRC16, plain output
  logic        b_msg_valid, b_msg_ready, b_tx_en, b_abort;
  logic [31:0] b_msg_data;
  logic        b_tx_bit, b_tx_valid, b_tx_last, b_busy;

  crc_serial_tx dut_a (
    .ck(ck), .rst(rst), .msg_valid(a_msg_valid), .msg_ready(a_msg_ready),
    .msg_data(a_msg_data), .tx_en(a_tx_en), .abort(a_abort), .tx_bit(a_tx_bit),
    .tx_valid(a_tx_valid), .tx_last(a_tx_last), .busy(a_busy)
  );

  crc_serial_tx #(
    .MSG_LEN(32), .CRC_W(16), .POLY(32'(CRC16_POLY)), .INIT(32'(CRC16_INIT)), .INVERT_OUT(1'b0)
  ) dut_b (
    .ck(ck), .rst(rst), .msg_valid(b_msg_valid), .msg_ready(b_msg_ready),
    .msg_data(b_msg_data), .tx_en(b_tx_en), .abort(b_abort), .tx_bit(b_tx_bit),
    .tx_valid(b_tx_valid), .tx_last(b_tx_last), .busy(b_busy)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge ck);
    #1;
  endtask

  // Remainder of (init*x^n + msg*x^w) mod G by polynomial long division
  function automatic logic [63:0] crc_ref(input logic [63:0] msg, input int n, input int w,
                                          input logic [63:0] poly, input logic [63:0] init);
    logic [63:0] v, gen, mask, m;
    mask = (64'd1 << w) - 64'd1;
    m    = (n >= 64) ? msg : (msg & ((64'd1 << n) - 64'd1));
    v    = (m << w) ^ ((init & mask) << n);
    gen  = (64'd1 << w) | (poly & mask);
    for (int i = n + w - 1; i >= w; i--)
      if (v[i]) v ^= gen << (i - w);
    return v & mask;
  endfunction

  function automatic logic [63:0] frame_ref(input logic [63:0] msg, input int n, input int w,
                                            input logic [63:0] poly, input logic [63:0] init,
                                            input bit inv);
    logic [63:0] c;
    c = crc_ref(msg, n, w, poly, init);
    if (inv) c ^= (64'd1 << w) - 64'd1;
    return (msg << w) | c;
  endfunction

  // Send one message on instance A and collect the frame
  task automatic run_a(input logic [10:0] m, input bit toggle, output logic [15:0] bits,
                       output int nbits, output int vcyc, output int last_at,
                       output int last_cnt, output int stall_bad);
    logic [2:0] snap;
    bits = '0; nbits = 0; vcyc = 0; last_at = 0; last_cnt = 0; stall_bad = 0;
    a_msg_data = m; a_msg_valid = 1'b1; a_tx_en = 1'b1;
    tick();
    a_msg_valid = 1'b0;
    for (int c = 0; c < 80 && a_tx_valid; c++) begin
      a_tx_en = toggle ? c[0] : 1'b1;
      vcyc++;
      if (a_tx_en) begin
        bits = {bits[14:0], a_tx_bit};
        nbits++;
        if (a_tx_last) begin last_cnt++; last_at = nbits; end
      end
      snap = {a_tx_bit, a_tx_valid, a_tx_last};
      tick();
      if (!a_tx_en && ({a_tx_bit, a_tx_valid, a_tx_last} !== snap)) stall_bad++;
    end
    a_tx_en = 1'b1;
  endtask

  typedef struct {
    logic [10:0] msg;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [15:0] bits;
    logic [31:0] got;
    int nbits, vcyc, last_at, last_cnt, stall_bad, n, gap, acc_at, acc;
    bit accepted, model_ready;
    bit expq[$];
    bit lastq[$];
    logic [47:0] fr;
    logic [63:0] f;

    rst = 1'b0;
    a_msg_valid = 0; a_msg_data = '0; a_tx_en = 1'b1; a_abort = 0;
    b_msg_valid = 0; b_msg_data = '0; b_tx_en = 1'b1; b_abort = 0;

    vecs[0] = '{11'h000, 16'h0008};
    vecs[1] = '{11'h408, 16'h0};
    vecs[2] = '{11'h7FF, 16'h0};
    vecs[3] = '{11'h555, 16'h0};
    vecs[4] = '{11'(($urandom)), 16'h0};
    vecs[5] = '{11'(($urandom)), 16'h0};
    for (int i = 1; i < 6; i++)
      vecs[i].exp = 16'(frame_ref(64'(vecs[i].msg), 11, 5, 64'(CRC5_POLY), 64'(CRC5_INIT), 1'b1));

    #2;
    chk("reset_outputs", {a_tx_bit, a_tx_valid, a_tx_last, a_busy}, 4'b0);
    chk("reset_ready", a_msg_ready, 1'b1);
    #6 rst = 1'b1;
    tick();

    // Table-driven frames, tx_en held high
    for (int i = 0; i < 6; i++) begin
      run_a(vecs[i].msg, 1'b0, bits, nbits, vcyc, last_at, last_cnt, stall_bad);
      chk($sformatf("frame_bits[%0d]", i), bits, vecs[i].exp);
      chk($sformatf("frame_len[%0d]", i), vcyc, 16);
      chk($sformatf("frame_last[%0d]", i), {last_cnt[7:0], last_at[7:0]}, {8'd1, 8'd16});
      chk($sformatf("frame_idle[%0d]", i), {a_busy, a_msg_ready}, 2'b01);
    end

    // Stall every other cycle
    run_a(11'h000, 1'b1, bits, nbits, vcyc, last_at, last_cnt, stall_bad);
    chk("stall_bits", bits, 16'h0008);
    chk("stall_cycles", vcyc, 32);
    chk("stall_hold", stall_bad, 0);
    chk("stall_last", {last_cnt[7:0], last_at[7:0]}, {8'd1, 8'd16});

    // Back-to-back frames with msg_valid held
    a_msg_data = 11'h000; a_msg_valid = 1'b1; a_tx_en = 1'b1;
    tick();
    a_msg_data = 11'h408;
    got = '0; n = 0; gap = 0; acc_at = -1; accepted = 0;
    for (int c = 0; c < 40 && n < 32; c++) begin
      if (!a_tx_valid) gap++;
      else begin got = {got[30:0], a_tx_bit}; n++; end
      if (a_msg_valid && a_msg_ready) begin acc_at = n; accepted = 1; end
      tick();
      if (accepted) a_msg_valid = 1'b0;
    end
    chk("b2b_bits", got, {16'h0008, 16'(frame_ref(64'h408, 11, 5, 64'(CRC5_POLY), 64'(CRC5_INIT), 1'b1))});
    chk("b2b_gap", gap, 0);
    chk("b2b_accept_at", acc_at, 16);
    chk("b2b_end", a_tx_valid, 1'b0);

    // Abort on the 7th message bit
    a_msg_data = 11'h7FF; a_msg_valid = 1'b1;
    tick();
    a_msg_valid = 1'b0;
    repeat (6) tick();
    chk("abort_pre_valid", a_tx_valid, 1'b1);
    a_abort = 1'b1;
    tick();
    a_abort = 1'b0;
    chk("abort_idle", {a_tx_valid, a_busy, a_msg_ready}, 3'b001);
    run_a(11'h000, 1'b0, bits, nbits, vcyc, last_at, last_cnt, stall_bad);
    chk("abort_next_frame", bits, 16'h0008);

    // Abort beats a back-to-back accept on the final CRC bit
    a_msg_data = 11'h123; a_msg_valid = 1'b1;
    tick();
    a_msg_data = 11'h456;
    for (int c = 0; c < 40 && !a_tx_last; c++) tick();
    chk("abort_b2b_at_last", a_tx_last, 1'b1);
    a_abort = 1'b1;
    #1;
    chk("abort_b2b_ready", a_msg_ready, 1'b0);
    tick();
    a_abort = 1'b0; a_msg_valid = 1'b0;
    chk("abort_b2b_idle", {a_tx_valid, a_busy}, 2'b00);

    // Asynchronous reset in the CRC phase (bit 13 of the all-zero frame is 1)
    a_msg_data = 11'h000; a_msg_valid = 1'b1;
    tick();
    a_msg_valid = 1'b0;
    repeat (12) tick();
    chk("rst_pre_bit", {a_tx_valid, a_tx_bit}, 2'b11);
    #2 rst = 1'b0;
    #1;
    chk("rst_async_outputs", {a_tx_bit, a_tx_valid, a_tx_last, a_busy}, 4'b0);
    #2 rst = 1'b1;
    #1;
    chk("rst_release_ready", a_msg_ready, 1'b1);
    tick();
    chk("rst_after_idle", {a_tx_valid, a_busy}, 2'b00);

    // Random CRC16 / 32-bit traffic against the queue model
    acc = 0; fr = '0;
    for (int c = 0; c < 20000 && (acc < 200 || expq.size() > 0); c++) begin
      b_tx_en     = ($urandom_range(0, 3) != 0);
      b_msg_valid = (acc < 200) && ($urandom_range(0, 1) == 1);
      b_msg_data  = $urandom;
      model_ready = (expq.size() == 0) || (expq.size() == 1 && b_tx_en);
      #1;
      if (expq.size() > 0)
        chk("rand_out", {b_tx_valid, b_tx_bit, b_tx_last, b_msg_ready},
            {1'b1, expq[0], lastq[0], model_ready});
      else
        chk("rand_out", {b_tx_valid, b_tx_bit, b_tx_last, b_msg_ready},
            {3'b000, model_ready});
      if (b_tx_en && expq.size() > 0) begin
        fr = {fr[46:0], b_tx_bit};
        if (lastq[0])
          chk("rand_residue", crc_ref(64'(fr), 48, 16, 64'(CRC16_POLY), 64'(CRC16_INIT)), 64'd0);
        void'(expq.pop_front());
        void'(lastq.pop_front());
      end
      if (b_msg_valid && model_ready) begin
        f = frame_ref(64'(b_msg_data), 32, 16, 64'(CRC16_POLY), 64'(CRC16_INIT), 1'b0);
        for (int i = 47; i >= 0; i--) begin
          expq.push_back(f[i]);
          lastq.push_back(i == 0);
        end
        acc++;
      end
      tick();
    end
    chk("rand_accepted", acc, 200);
    chk("rand_drained", expq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
